program_loader: RTL and testbench

//  Parametrised boot/load controller for the 5-stage MIPS pipeline. Accepts a byte

---
 rtl/program_loader.sv | 156 +++++++++++++++
 tb/tb_program_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: packs a byte stream into memory words, writes them from address 0,
// then releases the CPU from reset and runs it until halt or the cycle budget.
module program_loader_lane #(
  parameter int BYTE_W = 8
) (
  input  logic              clock,
  input  logic              clr,
  input  logic              ld,
  input  logic [BYTE_W-1:0] d,
  output logic [BYTE_W-1:0] merged
);
  logic [BYTE_W-1:0] q;

  always_ff @(posedge clock) begin
    if (clr)     q <= '0;
    else if (ld) q <= d;
  end

  // Incoming byte bypasses the register so the completing word is whole on its accept edge.
  assign merged = ld ? d : q;
endmodule

module program_loader #(
  parameter int BYTE_W     = 8,
  parameter int WORD_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 1024,
  parameter int BIG_ENDIAN = 1,
  parameter int MAX_CYCLES = 0
) (
  input  logic              clock,
  input  logic              reset_0,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_reset_0,
  input  logic              halt,
  output logic [31:0]       run_cycles,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              timeout,
  output logic              overflow
);
  localparam int              BPW         = WORD_W / BYTE_W;
  localparam int              LW          = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [ADDR_W:0] DEPTH_W     = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] WC_ONE      = (ADDR_W+1)'(1);
  localparam logic [LW-1:0]   LANE_ONE    = LW'(1);
  localparam logic [LW-1:0]   LANE_LAST   = LW'(BPW - 1);
  localparam logic [31:0]     BUDGET_LAST = 32'(MAX_CYCLES - 1);

  // S_FLUSH covers the cycle the final write strobe is on the bus, before the CPU runs.
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN, S_DONE, S_ERR} state_t;
  state_t state, state_n;

  logic [LW-1:0]              lane;
  logic [BPW-1:0][BYTE_W-1:0] lane_m;
  logic [WORD_W-1:0]          word_n;
  logic xfer, full, acc, ovf, wr, enter, budget, stop, lane_clr;

  assign xfer     = in_valid & in_ready;
  assign full     = (word_count == DEPTH_W);
  assign acc      = xfer & ~full;
  assign ovf      = xfer & full;
  assign wr       = acc & (in_last | (lane == LANE_LAST));
  assign enter    = start & (state == S_IDLE || state == S_DONE || state == S_ERR);
  assign budget   = (MAX_CYCLES != 0) && (run_cycles == BUDGET_LAST);
  assign stop     = halt | budget;
  assign lane_clr = ~reset_0 | enter | wr;

  for (genvar i = 0; i < BPW; i++) begin : g_lane
    program_loader_lane #(.BYTE_W(BYTE_W)) u_lane (
      .clock  (clock),
      .clr    (lane_clr),
      .ld     (acc && (lane == LW'(i))),
      .d      (in_data),
      .merged (lane_m[i])
    );
    if (BIG_ENDIAN != 0) begin : g_be
      assign word_n[WORD_W-1-i*BYTE_W -: BYTE_W] = lane_m[i];
    end else begin : g_le
      assign word_n[i*BYTE_W +: BYTE_W] = lane_m[i];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_0) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_n = S_LOAD;
      S_LOAD: begin
        if (ovf)                 state_n = S_ERR;
        else if (wr && in_last)  state_n = S_FLUSH;
      end
      S_FLUSH: state_n = S_RUN;
      S_RUN:   if (stop) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_0) begin
      in_ready    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_reset_0 <= 1'b0;
      run_cycles  <= '0;
      word_count  <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      overflow    <= 1'b0;
      lane        <= '0;
    end else begin
      in_ready    <= (state_n == S_LOAD);
      mem_we      <= wr;
      cpu_reset_0 <= (state_n == S_RUN);
      if (wr) begin
        mem_addr  <= word_count[ADDR_W-1:0];
        mem_wdata <= word_n;
      end
      if (enter) begin
        word_count <= '0;
        run_cycles <= '0;
        done       <= 1'b0;
        timeout    <= 1'b0;
        overflow   <= 1'b0;
        lane       <= '0;
      end else begin
        if (wr) begin
          word_count <= word_count + WC_ONE;
          lane       <= '0;
        end else if (acc) begin
          lane <= lane + LANE_ONE;
        end
        if (ovf) overflow <= 1'b1;
        if (state == S_RUN) begin
          if (run_cycles != '1) run_cycles <= run_cycles + 32'd1;
          if (stop) begin
            done    <= 1'b1;
            timeout <= ~halt;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Directed bench: instance A is big-endian with DEPTH=4 and a 16-cycle budget,
// instance B is little-endian with defaults; both share the stimulus.
module tb_program_loader;
  logic       clock = 1'b0, reset_0 = 1'b0, start = 1'b0;
  logic       in_valid = 1'b0, in_last = 1'b0, halt = 1'b0;
  logic [7:0] in_data = '0;

  logic        ready_a, we_a, cr_a, done_a, to_a, ovf_a;
  logic [9:0]  addr_a;
  logic [31:0] wd_a, rc_a;
  logic [10:0] wc_a;
  logic        ready_b, we_b, cr_b, done_b, to_b, ovf_b;
  logic [9:0]  addr_b;
  logic [31:0] wd_b, rc_b;
  logic [10:0] wc_b;

  int checks = 0, errors = 0;
  int nwr_a = 0, nwr_b = 0, snap = 0;
  logic [31:0] mem_a [0:1023];
  logic [31:0] mem_b [0:1023];
  logic [7:0]  t1 [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
  logic [7:0]  t2 [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

  program_loader #(.BIG_ENDIAN(1), .DEPTH(4), .MAX_CYCLES(16)) u_a (
    .clock(clock), .reset_0(reset_0), .start(start), .in_valid(in_valid), .in_ready(ready_a),
    .in_data(in_data), .in_last(in_last), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
    .cpu_reset_0(cr_a), .halt(halt), .run_cycles(rc_a), .word_count(wc_a), .done(done_a),
    .timeout(to_a), .overflow(ovf_a));

  program_loader #(.BIG_ENDIAN(0)) u_b (
    .clock(clock), .reset_0(reset_0), .start(start), .in_valid(in_valid), .in_ready(ready_b),
    .in_data(in_data), .in_last(in_last), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
    .cpu_reset_0(cr_b), .halt(halt), .run_cycles(rc_b), .word_count(wc_b), .done(done_b),
    .timeout(to_b), .overflow(ovf_b));

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (we_a) begin mem_a[addr_a] = wd_a; nwr_a++; end
    if (we_b) begin mem_b[addr_b] = wd_b; nwr_b++; end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic l, input int gap);
    int n = 0;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1; in_data = b; in_last = l;
    while (!ready_a && n < 50) begin tick(); n++; end
    if (n >= 50) check("send_ready_timeout", {63'd0, ready_a}, 64'd1);
    @(posedge clock);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_reset();
    reset_0 = 1'b0;
    tick();
    reset_0 = 1'b1;
  endtask

  initial begin
    tick(); tick();
    check("rst_flags", {ready_a, we_a, cr_a, done_a, to_a, ovf_a, ready_b, cr_b, ovf_b}, 9'd0);
    check("rst_addr", addr_a, 10'd0);
    check("rst_wdata", wd_a, 32'd0);
    check("rst_cycles", rc_a, 32'd0);
    check("rst_wcount", wc_a, 11'd0);
    reset_0 = 1'b1;
    tick();
    check("idle_ready", ready_a, 1'b0);

    // program image, big-endian
    go();
    check("load_ready", ready_a, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(t1[i], i == 7, 0);
      if (i == 3) check("t1_w0", {we_a, addr_a, wd_a}, {1'b1, 10'd0, 32'h20080005});
    end
    check("t1_w1", {we_a, addr_a, wd_a}, {1'b1, 10'd1, 32'h8C090004});
    check("t1_wc", wc_a, 11'd2);
    check("t1_cpu_held", {cr_a, ready_a}, 2'b00);
    tick();
    check("t1_cpu_run", {cr_a, we_a}, 2'b10);
    check("t1_rc0", rc_a, 32'd0);
    check("t1_mem0", mem_a[0], 32'h20080005);

    // halt on the 10th run cycle; start mid-run is ignored
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_run", {cr_a, ready_a}, 2'b10);
    repeat (4) tick();
    check("t3_rc9", rc_a, 32'd9);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("t3_done", {done_a, to_a, cr_a}, 3'b100);
    check("t3_rc", rc_a, 32'd10);
    check("t3_b_done", {done_b, cr_b}, 2'b10);

    // partial final word, both endiannesses
    go();
    for (int i = 0; i < 6; i++) send(t2[i], i == 5, 0);
    check("t2_be_w1", {addr_a, wd_a}, {10'd1, 32'hEEFF0000});
    check("t2_le_w1", {addr_b, wd_b}, {10'd1, 32'h0000FFEE});
    check("t2_be_w0", mem_a[0], 32'hAABBCCDD);
    check("t2_le_w0", mem_b[0], 32'hDDCCBBAA);
    check("t2_wc", {wc_a, wc_b}, {11'd2, 11'd2});
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("t2_halt_first", {done_a, to_a, rc_a}, {2'b10, 32'd1});
    check("t2_b_halt", {done_b, to_b, rc_b}, {2'b10, 32'd1});

    // cycle budget on A, halt never raised
    go();
    for (int i = 0; i < 4; i++) send(8'h11 * (i + 1), i == 3, 0);
    begin
      int n = 0;
      while (!done_a && n < 40) begin tick(); n++; end
    end
    check("t4_done", {done_a, to_a, cr_a}, 3'b110);
    check("t4_rc", rc_a, 32'd16);
    tick();
    check("t4_rc_hold", rc_a, 32'd16);
    check("t4_b_running", {cr_b, done_b}, 2'b10);

    // overflow on A with DEPTH=4
    snap = nwr_a;
    go();
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, i % 3);
    check("t5_writes", nwr_a - snap, 4);
    check("t5_w3", mem_a[3], 32'h0C0D0E0F);
    check("t5_pre", {wc_a, ovf_a, ready_a}, {11'd4, 2'b01});
    in_valid = 1'b1; in_data = 8'h10;
    @(posedge clock);
    tick();
    check("t5_ovf", {ovf_a, ready_a, cr_a, we_a}, 4'b1000);
    check("t5_wc", wc_a, 11'd4);
    for (int i = 0; i < 3; i++) begin in_data = 8'h11 + 8'(i); tick(); end
    in_valid = 1'b0;
    check("t5_no_more", nwr_a - snap, 4);
    check("t5_sticky", {ovf_a, cr_a}, 2'b10);

    // reset mid-load, then a clean reload
    go();
    check("t6_start_clr", {ovf_a, ready_a}, 2'b01);
    for (int i = 0; i < 3; i++) send(8'hAA + 8'(i), 1'b0, 0);
    snap = nwr_a;
    pulse_reset();
    check("t6_rst", {ready_a, we_a, cr_a, wc_a, wd_a}, 46'd0);
    tick();
    check("t6_no_wr", nwr_a - snap, 0);
    mem_a[0] = '0; mem_b[0] = '0;
    go();
    for (int i = 0; i < 4; i++) send(8'(i + 1), i == 3, 0);
    check("t6_be", mem_a[0], 32'h01020304);
    check("t6_le", mem_b[0], 32'h04030201);
    check("t6_once", {nwr_a - snap, 21'd0, wc_a}, {32'd1, 21'd0, 11'd1});
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;

    // same image with random input gaps
    snap = nwr_a;
    mem_a[0] = '0;
    go();
    for (int i = 0; i < 4; i++) send(8'(i + 1), i == 3, $urandom_range(0, 3));
    check("t6_gap_be", mem_a[0], 32'h01020304);
    check("t6_gap_once", nwr_a - snap, 1);
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;

    // partial word after a reset must not inherit bytes from the aborted load
    go();
    for (int i = 0; i < 3; i++) send(8'hAA + 8'(i), 1'b0, 0);
    pulse_reset();
    mem_a[0] = '0; mem_b[0] = '0;
    go();
    send(8'h01, 1'b0, 0);
    send(8'h02, 1'b1, 1);
    check("stale_be", mem_a[0], 32'h01020000);
    check("stale_le", mem_b[0], 32'h00000201);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
